scale_pass_controller: RTL and testbench

- Frame-level sequencer for the multi-scale detection flow.
- Per frame, walks scale indices 0,1,2,… and for each index:
  - requests parameters from the scale parameter generator;
  - checks the scaled image still fits one detection window;
  - hands a pass descriptor to the resize/cascade pipeline.
- Prefetches the next scale's parameters while the current pass runs, hiding divider latency.
- Sits between the frame control logic and the scale parameter generator / resize engine.

---
 rtl/scale_pass_controller_pkg.sv | 34 +++
 rtl/scale_param_buffer.sv | 31 +++
 rtl/scale_pass_controller.sv | 225 ++++++++++++++++++++++
 tb/tb_scale_pass_controller.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/scale_pass_controller_pkg.sv
// Shared types, widths and defaults for the scale pass controller slice.
package scale_pass_controller_pkg;
    localparam int DIM_W          = 10;
    localparam int IDX_W          = 5;
    localparam int INV_W          = 16;
    localparam int DEF_MAX_SCALES = 32;
    localparam int DEF_BASE_WIN   = 24;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_REQ_PARAM  = 3'd1,
        S_WAIT_PARAM = 3'd2,
        S_CHECK      = 3'd3,
        S_ISSUE      = 3'd4,
        S_WAIT_PASS  = 3'd5,
        S_DRAIN      = 3'd6,
        S_DONE       = 3'd7
    } state_t;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [DIM_W-1:0] w;
        logic [DIM_W-1:0] h;
        logic [INV_W-1:0] inv_s;
        logic [DIM_W-1:0] win_size;
    } scale_params_t;

    // A scaled image is worth a pass only if one detection window still fits.
    function automatic logic fits_window(input logic [DIM_W-1:0] w,
                                         input logic [DIM_W-1:0] h,
                                         input logic [DIM_W-1:0] base);
        return (w >= base) && (h >= base);
    endfunction
endpackage

// File: rtl/scale_param_buffer.sv
// One-entry holding register for a generated scale parameter set.
module scale_param_buffer
    import scale_pass_controller_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          clear,
    input  scale_params_t din,
    output scale_params_t dout,
    output logic          valid
);
    scale_params_t data_r;
    logic          valid_r;

    // Entry storage; clear takes priority so an abort can never leave a live entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_r  <= '0;
            valid_r <= 1'b0;
        end else if (clear) begin
            valid_r <= 1'b0;
        end else if (load) begin
            data_r  <= din;
            valid_r <= 1'b1;
        end
    end

    assign dout  = data_r;
    assign valid = valid_r;
endmodule

// File: rtl/scale_pass_controller.sv
// Per-frame scale sequencer: requests scale parameters, filters passes that no
// longer fit a window, and prefetches the next scale while the current pass runs.
module scale_pass_controller
    import scale_pass_controller_pkg::*;
#(
    parameter int MAX_SCALES = DEF_MAX_SCALES,
    parameter int BASE_WIN   = DEF_BASE_WIN
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_start,
    input  logic [DIM_W-1:0] img_width,
    input  logic [DIM_W-1:0] img_height,
    input  logic             abort,
    output logic             param_start,
    output logic [IDX_W-1:0] param_scale_idx,
    input  logic             param_done,
    input  logic [DIM_W-1:0] param_new_w,
    input  logic [DIM_W-1:0] param_new_h,
    input  logic [INV_W-1:0] param_inv_s,
    input  logic [DIM_W-1:0] param_win_size,
    output logic             pass_valid,
    input  logic             pass_ready,
    output logic [IDX_W-1:0] pass_scale_idx,
    output logic [DIM_W-1:0] pass_w,
    output logic [DIM_W-1:0] pass_h,
    output logic [INV_W-1:0] pass_inv_s,
    output logic [DIM_W-1:0] pass_win_size,
    input  logic             pass_done,
    output logic             busy,
    output logic             frame_done,
    output logic [IDX_W:0]   scales_processed
);
    localparam int               CNT_W    = IDX_W + 1;
    localparam logic [IDX_W:0]   MAX_IDX  = CNT_W'(MAX_SCALES);
    localparam logic [IDX_W:0]   IDX_ONE  = CNT_W'(1);
    localparam logic [DIM_W-1:0] BASE_DIM = DIM_W'(BASE_WIN);

    state_t           state_r, state_s;
    logic [IDX_W:0]   next_idx_r, next_idx_s, idx_inc_s, scales_r, scales_s;
    logic [IDX_W-1:0] req_idx_r, req_idx_s;
    logic             outstanding_r, busy_r, busy_s, param_start_r, param_start_s;
    logic             pass_valid_r, pass_valid_s, frame_done_r, frame_done_s;
    logic             pass_load_s, pass_clr_s, buf_load_s, buf_clr_s, resp_s, abort_s;
    logic             buf_valid_s;
    scale_params_t    buf_din_s, buf_q_s, pass_data_r;

    // Only a response to our own request counts; strays are dropped.
    assign resp_s     = param_done && outstanding_r;
    assign abort_s    = abort && (state_r != S_IDLE);
    assign idx_inc_s  = next_idx_r + IDX_ONE;
    assign buf_load_s = resp_s && !abort_s && (state_r != S_DRAIN);
    assign buf_din_s  = '{idx: req_idx_r, w: param_new_w, h: param_new_h,
                          inv_s: param_inv_s, win_size: param_win_size};

    scale_param_buffer u_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (buf_load_s),
        .clear (buf_clr_s),
        .din   (buf_din_s),
        .dout  (buf_q_s),
        .valid (buf_valid_s)
    );

    // Next-state and next-register values; abort preempts the normal walk.
    always_comb begin
        state_s       = state_r;
        next_idx_s    = next_idx_r;
        req_idx_s     = req_idx_r;
        scales_s      = scales_r;
        busy_s        = busy_r;
        pass_valid_s  = pass_valid_r;
        param_start_s = 1'b0;
        frame_done_s  = 1'b0;
        pass_load_s   = 1'b0;
        pass_clr_s    = 1'b0;
        buf_clr_s     = 1'b0;
        if (abort_s) begin
            pass_valid_s = 1'b0;
            pass_clr_s   = 1'b0 | 1'b1;
            buf_clr_s    = 1'b1;
            if (outstanding_r && !resp_s) begin
                state_s = S_DRAIN;
            end else begin
                state_s = S_IDLE;
                busy_s  = 1'b0;
            end
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (frame_start) begin
                        busy_s     = 1'b1;
                        scales_s   = '0;
                        next_idx_s = '0;
                        req_idx_s  = '0;
                        pass_clr_s = 1'b1;
                        if (fits_window(img_width, img_height, BASE_DIM)) begin
                            state_s       = S_REQ_PARAM;
                            param_start_s = 1'b1;
                        end else begin
                            state_s = S_DONE;
                        end
                    end else begin
                        state_s = S_IDLE;
                    end
                end
                S_REQ_PARAM: state_s = S_WAIT_PARAM;
                S_WAIT_PARAM: begin
                    if (resp_s) begin
                        state_s = S_CHECK;
                    end else begin
                        state_s = S_WAIT_PARAM;
                    end
                end
                S_CHECK: begin
                    if (!fits_window(buf_q_s.w, buf_q_s.h, BASE_DIM) || (next_idx_r >= MAX_IDX)) begin
                        state_s   = S_DONE;
                        buf_clr_s = 1'b1;
                    end else begin
                        state_s      = S_ISSUE;
                        pass_valid_s = 1'b1;
                        pass_load_s  = 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (pass_ready) begin
                        state_s      = S_WAIT_PASS;
                        pass_valid_s = 1'b0;
                        buf_clr_s    = 1'b1;
                        scales_s     = scales_r + IDX_ONE;
                        next_idx_s   = idx_inc_s;
                        // Prefetch the following scale so the divider overlaps this pass.
                        if (idx_inc_s < MAX_IDX) begin
                            param_start_s = 1'b1;
                            req_idx_s     = idx_inc_s[IDX_W-1:0];
                        end else begin
                            req_idx_s = req_idx_r;
                        end
                    end else begin
                        state_s = S_ISSUE;
                    end
                end
                S_WAIT_PASS: begin
                    if (pass_done) begin
                        if (buf_valid_s || resp_s) begin
                            state_s = S_CHECK;
                        end else if (outstanding_r) begin
                            state_s = S_WAIT_PARAM;
                        end else begin
                            state_s = S_DONE;
                        end
                    end else begin
                        state_s = S_WAIT_PASS;
                    end
                end
                S_DRAIN: begin
                    if (resp_s || !outstanding_r) begin
                        state_s = S_IDLE;
                        busy_s  = 1'b0;
                    end else begin
                        state_s = S_DRAIN;
                    end
                end
                S_DONE: begin
                    state_s      = S_IDLE;
                    busy_s       = 1'b0;
                    frame_done_s = 1'b1;
                    buf_clr_s    = 1'b1;
                end
                default: begin
                    state_s = S_IDLE;
                    busy_s  = 1'b0;
                end
            endcase
        end
    end

    // Control state and every externally visible output are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= S_IDLE;
            next_idx_r    <= '0;
            req_idx_r     <= '0;
            scales_r      <= '0;
            busy_r        <= 1'b0;
            param_start_r <= 1'b0;
            pass_valid_r  <= 1'b0;
            frame_done_r  <= 1'b0;
            outstanding_r <= 1'b0;
            pass_data_r   <= '0;
        end else begin
            state_r       <= state_s;
            next_idx_r    <= next_idx_s;
            req_idx_r     <= req_idx_s;
            scales_r      <= scales_s;
            busy_r        <= busy_s;
            param_start_r <= param_start_s;
            pass_valid_r  <= pass_valid_s;
            frame_done_r  <= frame_done_s;
            if (param_start_s) begin
                outstanding_r <= 1'b1;
            end else if (resp_s) begin
                outstanding_r <= 1'b0;
            end
            if (pass_clr_s) begin
                pass_data_r <= '0;
            end else if (pass_load_s) begin
                pass_data_r <= buf_q_s;
            end
        end
    end

    assign param_start      = param_start_r;
    assign param_scale_idx  = req_idx_r;
    assign pass_valid       = pass_valid_r;
    assign pass_scale_idx   = pass_data_r.idx;
    assign pass_w           = pass_data_r.w;
    assign pass_h           = pass_data_r.h;
    assign pass_inv_s       = pass_data_r.inv_s;
    assign pass_win_size    = pass_data_r.win_size;
    assign busy             = busy_r;
    assign frame_done       = frame_done_r;
    assign scales_processed = scales_r;
endmodule

// File: tb/tb_scale_pass_controller.sv
// Directed bench for scale_pass_controller with generator and downstream models.
module tb_scale_pass_controller;
    import scale_pass_controller_pkg::*;

    logic             clk, rst_n, frame_start, abort, param_start, param_done;
    logic             pass_valid, pass_ready, pass_done, busy, frame_done;
    logic [DIM_W-1:0] img_width, img_height, param_new_w, param_new_h, param_win_size;
    logic [DIM_W-1:0] pass_w, pass_h, pass_win_size;
    logic [IDX_W-1:0] param_scale_idx, pass_scale_idx;
    logic [INV_W-1:0] param_inv_s, pass_inv_s;
    logic [IDX_W:0]   scales_processed;

    int tests_run = 0, tests_failed = 0;
    int ps_cnt = 0, hs_cnt = 0, fd_cnt = 0, coinc_cnt = 0;
    int ps_base = 0, hs_base = 0, fd_base = 0, coinc_base = 0;
    int gen_lat = 20, pass_len = 30, gen_idx = 0, hs_k = 0;
    bit gen_const = 1'b0;
    // floor(320 / 1.25^i) and floor(240 / 1.25^i)
    int w_tab [0:11] = '{320, 256, 204, 163, 131, 104, 83, 67, 53, 42, 34, 27};
    int h_tab [0:11] = '{240, 192, 153, 122, 98, 78, 62, 50, 40, 32, 25, 20};

    scale_pass_controller dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
        .img_width(img_width), .img_height(img_height), .abort(abort),
        .param_start(param_start), .param_scale_idx(param_scale_idx),
        .param_done(param_done), .param_new_w(param_new_w), .param_new_h(param_new_h),
        .param_inv_s(param_inv_s), .param_win_size(param_win_size),
        .pass_valid(pass_valid), .pass_ready(pass_ready), .pass_scale_idx(pass_scale_idx),
        .pass_w(pass_w), .pass_h(pass_h), .pass_inv_s(pass_inv_s),
        .pass_win_size(pass_win_size), .pass_done(pass_done), .busy(busy),
        .frame_done(frame_done), .scales_processed(scales_processed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input int got, input int exp);
        tests_run++;
        if (got != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Scale parameter generator model: fixed latency, table or constant results.
    initial begin
        param_done = 1'b0; param_new_w = '0; param_new_h = '0;
        param_inv_s = '0; param_win_size = '0;
        forever begin
            @(negedge clk);
            if (param_start) begin
                gen_idx = int'(param_scale_idx);
                repeat (gen_lat) @(posedge clk);
                #1;
                param_done     = 1'b1;
                param_new_w    = gen_const ? 10'd1000 : ((gen_idx < 12) ? DIM_W'(w_tab[gen_idx]) : 10'd0);
                param_new_h    = gen_const ? 10'd1000 : ((gen_idx < 12) ? DIM_W'(h_tab[gen_idx]) : 10'd0);
                param_inv_s    = INV_W'(1000 + gen_idx);
                param_win_size = DIM_W'(24 + gen_idx);
                @(posedge clk);
                #1 param_done = 1'b0;
            end
        end
    end

    // Downstream model: pass_done pulse pass_len cycles after each handshake.
    initial begin
        pass_done = 1'b0;
        forever begin
            @(negedge clk);
            if (pass_valid && pass_ready) begin
                repeat (pass_len) @(posedge clk);
                #1 pass_done = 1'b1;
                @(posedge clk);
                #1 pass_done = 1'b0;
            end
        end
    end

    // Event counters and per-handshake descriptor checks.
    always @(negedge clk) begin
        if (param_start) ps_cnt++;
        if (frame_done) fd_cnt++;
        if (pass_done && param_done) coinc_cnt++;
        if (pass_valid && pass_ready) begin
            hs_k = hs_cnt - hs_base;
            chk_eq("hs_idx", int'(pass_scale_idx), hs_k);
            chk_eq("hs_w", int'(pass_w), gen_const ? 1000 : ((hs_k < 12) ? w_tab[hs_k] : 0));
            chk_eq("hs_h", int'(pass_h), gen_const ? 1000 : ((hs_k < 12) ? h_tab[hs_k] : 0));
            chk_eq("hs_inv", int'(pass_inv_s), 1000 + hs_k);
            chk_eq("hs_win", int'(pass_win_size), 24 + hs_k);
            hs_cnt++;
        end
    end

    task automatic start_frame(input int w, input int h);
        @(posedge clk);
        #1;
        hs_base = hs_cnt; ps_base = ps_cnt; fd_base = fd_cnt; coinc_base = coinc_cnt;
        img_width = DIM_W'(w); img_height = DIM_W'(h); frame_start = 1'b1;
        @(posedge clk);
        #1 frame_start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        while (fd_cnt == fd_base && n < limit) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic check_frame(input int exp_hs, input int exp_ps);
        chk_eq("frame_passes", hs_cnt - hs_base, exp_hs);
        chk_eq("frame_param_starts", ps_cnt - ps_base, exp_ps);
        chk_eq("frame_done_pulses", fd_cnt - fd_base, 1);
        chk_eq("frame_scales", int'(scales_processed), exp_hs);
        chk_eq("frame_busy_low", int'(busy), 0);
    endtask

    initial begin
        int n, bad;
        logic [IDX_W-1:0] cap_idx;
        logic [DIM_W-1:0] cap_w, cap_h, cap_win;
        logic [INV_W-1:0] cap_inv;
        rst_n = 1'b0; frame_start = 1'b0; abort = 1'b0; pass_ready = 1'b1;
        img_width = '0; img_height = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk_eq("rst_busy", int'(busy), 0);
        chk_eq("rst_pass_valid", int'(pass_valid), 0);
        chk_eq("rst_param_start", int'(param_start), 0);
        chk_eq("rst_frame_done", int'(frame_done), 0);
        chk_eq("rst_scales", int'(scales_processed), 0);

        // 320x240, results arrive before pass_done
        start_frame(320, 240);
        wait_done(3000);
        check_frame(11, 12);

        // pass_done coincides with prefetch param_done; a busy frame_start is ignored
        pass_len = 21;
        start_frame(320, 240);
        repeat (100) @(posedge clk);
        #1 img_width = 10'd20; img_height = 10'd20; frame_start = 1'b1;
        @(posedge clk);
        #1 frame_start = 1'b0;
        wait_done(3000);
        check_frame(11, 12);
        chk_eq("coinc_seen", (coinc_cnt - coinc_base) > 0 ? 1 : 0, 1);

        // Backpressure on idx 3, short passes so the result arrives after pass_done
        pass_len = 5;
        start_frame(320, 240);
        n = 0;
        while (hs_cnt - hs_base < 3 && n < 2000) begin
            @(posedge clk);
            #1 n++;
        end
        pass_ready = 1'b0;
        n = 0;
        while (!pass_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk_eq("bp_valid", int'(pass_valid), 1);
        chk_eq("bp_idx", int'(pass_scale_idx), 3);
        chk_eq("bp_w", int'(pass_w), 163);
        cap_idx = pass_scale_idx; cap_w = pass_w; cap_h = pass_h;
        cap_inv = pass_inv_s; cap_win = pass_win_size;
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (!pass_valid || pass_scale_idx != cap_idx || pass_w != cap_w ||
                pass_h != cap_h || pass_inv_s != cap_inv || pass_win_size != cap_win) bad++;
        end
        chk_eq("bp_stable", bad, 0);
        chk_eq("bp_hold_scales", int'(scales_processed), 3);
        @(posedge clk);
        #1 pass_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk_eq("bp_release_scales", int'(scales_processed), 4);
        wait_done(3000);
        check_frame(11, 12);

        // Abort 5 cycles after the idx 2 prefetch request
        pass_len = 30;
        start_frame(320, 240);
        n = 0;
        while (ps_cnt - ps_base < 3 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        chk_eq("ab_busy_drain", int'(busy), 1);
        chk_eq("ab_pass_valid", int'(pass_valid), 0);
        chk_eq("ab_param_start", int'(param_start), 0);
        chk_eq("ab_pass_w_clr", int'(pass_w), 0);
        chk_eq("ab_pass_idx_clr", int'(pass_scale_idx), 0);
        chk_eq("ab_scales_held", int'(scales_processed), 2);
        n = 0;
        while (!param_done && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk_eq("ab_late_done", int'(param_done), 1);
        chk_eq("ab_busy_at_late_done", int'(busy), 1);
        @(negedge clk);
        chk_eq("ab_busy_after_drain", int'(busy), 0);
        chk_eq("ab_no_frame_done", fd_cnt - fd_base, 0);
        repeat (40) @(posedge clk);
        start_frame(320, 240);
        wait_done(3000);
        check_frame(11, 12);

        // Scale cap: generator never shrinks the image
        gen_const = 1'b1; gen_lat = 3; pass_len = 4;
        start_frame(320, 240);
        wait_done(5000);
        check_frame(32, 32);

        // Image smaller than one window: immediate frame_done
        gen_const = 1'b0;
        @(posedge clk);
        #1;
        ps_base = ps_cnt; fd_base = fd_cnt;
        img_width = 10'd20; img_height = 10'd240; frame_start = 1'b1;
        @(posedge clk);
        #1 frame_start = 1'b0;
        @(negedge clk);
        chk_eq("small_fd_c1", int'(frame_done), 0);
        chk_eq("small_busy_c1", int'(busy), 1);
        @(negedge clk);
        chk_eq("small_fd_c2", int'(frame_done), 1);
        chk_eq("small_busy_c2", int'(busy), 0);
        repeat (3) @(negedge clk);
        chk_eq("small_param_starts", ps_cnt - ps_base, 0);
        chk_eq("small_scales", int'(scales_processed), 0);
        chk_eq("small_fd_pulses", fd_cnt - fd_base, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
